// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port sequencer sharing one single-port synchronous RAM.
// Each grant runs IDLE -> ACCESS -> RESP and completes with a registered one-cycle ack.
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic          a_err,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic          b_err,
   output logic [DW-1:0] b_rdata,
   output logic          Mem_WrEn,
   output logic [AW-1:0] ALU_MEM_Addr,
   output logic [DW-1:0] MEM_DataIn,
   input  logic [DW-1:0] MEM_DataOut,
   output logic [1:0]    dbgState
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arbStateT;

   arbStateT      state;
   logic          ptrB;
   logic          winB;
   logic          latWe;
   logic          latMis;

   logic          aPend;
   logic          bPend;
   logic          grantB;
   logic          selWe;
   logic [AW-1:0] selAddr;
   logic [DW-1:0] selWdata;

   // Handshake: a requester raises req with we/addr/wdata stable and holds it until its
   // one-cycle ack; req must drop in the ack cycle, and a port whose ack is high is not
   // eligible that cycle, so a stale req is never granted twice.
   always_comb begin
      aPend    = a_req & ~a_ack;
      bPend    = b_req & ~b_ack;
      grantB   = bPend & (~aPend | ptrB);
      selWe    = grantB ? b_we : a_we;
      selAddr  = grantB ? b_addr : a_addr;
      selWdata = grantB ? b_wdata : a_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         ptrB         <= 1'b0;
         winB         <= 1'b0;
         latWe        <= 1'b0;
         latMis       <= 1'b0;
         a_ack        <= 1'b0;
         a_err        <= 1'b0;
         a_rdata      <= '0;
         b_ack        <= 1'b0;
         b_err        <= 1'b0;
         b_rdata      <= '0;
         Mem_WrEn     <= 1'b0;
         ALU_MEM_Addr <= '0;
         MEM_DataIn   <= '0;
      end else begin
         a_ack <= 1'b0;
         a_err <= 1'b0;
         b_ack <= 1'b0;
         b_err <= 1'b0;
         case (state)
            IDLE: begin
               Mem_WrEn <= 1'b0;
               if (aPend | bPend) begin
                  // Address and write data are latched straight into the RAM-facing registers.
                  winB         <= grantB;
                  latWe        <= selWe;
                  latMis       <= (selAddr[1:0] != 2'b00);
                  ALU_MEM_Addr <= selAddr;
                  MEM_DataIn   <= selWdata;
                  Mem_WrEn     <= selWe & (selAddr[1:0] == 2'b00);
                  state        <= ACCESS;
               end
            end
            ACCESS: begin
               Mem_WrEn <= 1'b0;
               state    <= RESP;
            end
            RESP: begin
               Mem_WrEn <= 1'b0;
               ptrB     <= ~winB;
               state    <= IDLE;
               if (winB) begin
                  b_ack <= 1'b1;
                  b_err <= latMis;
                  if (!latMis && !latWe) b_rdata <= MEM_DataOut;
               end else begin
                  a_ack <= 1'b1;
                  a_err <= latMis;
                  if (!latMis && !latWe) a_rdata <= MEM_DataOut;
               end
            end
            default: begin
               Mem_WrEn <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign dbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus concurrent random traffic from both ports,
// responses checked from an expected queue per port against a word-array memory model.
module tb_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        a_req, a_we, b_req, b_we;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ack, a_err, b_ack, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic        Mem_WrEn;
   logic [31:0] ALU_MEM_Addr, MEM_DataIn, MEM_DataOut;
   logic [1:0]  dbgState;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wrCount = 0;
   int expWr = 0;
   logic [31:0] lastWrAddr = '0;

   logic [31:0] ram [0:1023];
   logic        ramLoaded = 1'b0;
   logic [31:0] refMem [0:1023];
   logic [31:0] lastRd [2];
   logic [31:0] heldRd [2];
   logic [32:0] expAQ [$];
   logic [32:0] expBQ [$];

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .Mem_WrEn(Mem_WrEn), .ALU_MEM_Addr(ALU_MEM_Addr), .MEM_DataIn(MEM_DataIn),
      .MEM_DataOut(MEM_DataOut), .dbgState(dbgState)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] initWord(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
   endfunction

   // synchronous RAM environment: data valid the cycle after the address
   always @(posedge clk) begin
      if (!ramLoaded) begin
         for (int i = 0; i < 1024; i++) ram[i] <= initWord(i);
         ramLoaded <= 1'b1;
      end else if (Mem_WrEn) begin
         ram[ALU_MEM_Addr[11:2]] <= MEM_DataIn;
         wrCount <= wrCount + 1;
         lastWrAddr <= ALU_MEM_Addr;
      end
      MEM_DataOut <= ram[ALU_MEM_Addr[11:2]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: response of one request computed from the port rules
   function automatic void expectOp(input int p, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wd);
      logic [32:0] e;
      int idx;
      idx = int'(addr[11:2]);
      if (addr[1:0] != 2'b00) begin
         e = {1'b1, lastRd[p]};
      end else if (we) begin
         refMem[idx] = wd;
         expWr++;
         e = {1'b0, lastRd[p]};
      end else begin
         lastRd[p] = refMem[idx];
         e = {1'b0, lastRd[p]};
      end
      if (p == 0) expAQ.push_back(e);
      else expBQ.push_back(e);
   endfunction

   task automatic doReq(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      int n;
      logic ack;
      @(posedge clk);
      #1;
      expectOp(p, we, addr, wd);
      if (p == 0) begin
         a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
      end else begin
         b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
      end
      n = 0;
      ack = 1'b0;
      while (!ack && n < 20) begin
         @(negedge clk);
         n++;
         ack = (p == 0) ? a_ack : b_ack;
      end
      check(p == 0 ? "a_req_acked" : "b_req_acked", ack, 1);
      if (p == 0) a_req = 1'b0;
      else b_req = 1'b0;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      lastRd = '{32'h0, 32'h0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // scoreboard monitor
   initial begin
      logic pa, pb, pw;
      pa = 1'b0; pb = 1'b0; pw = 1'b0;
      heldRd = '{32'h0, 32'h0};
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            heldRd = '{32'h0, 32'h0};
         end else begin
            if (a_ack) begin
               if (expAQ.size() == 0) check("a_ack_unexpected", 1, 0);
               else begin
                  check("a_resp", {a_err, a_rdata}, expAQ[0]);
                  heldRd[0] = expAQ[0][31:0];
                  void'(expAQ.pop_front());
               end
               check("a_ack_pulse", pa, 0);
               check("b_rdata_hold", b_rdata, heldRd[1]);
            end
            if (b_ack) begin
               if (expBQ.size() == 0) check("b_ack_unexpected", 1, 0);
               else begin
                  check("b_resp", {b_err, b_rdata}, expBQ[0]);
                  heldRd[1] = expBQ[0][31:0];
                  void'(expBQ.pop_front());
               end
               check("b_ack_pulse", pb, 0);
               check("a_rdata_hold", a_rdata, heldRd[0]);
            end
            if (Mem_WrEn) begin
               check("wren_aligned", ALU_MEM_Addr[1:0], 0);
               check("wren_single", pw, 0);
            end
         end
         pa = a_ack; pb = b_ack; pw = Mem_WrEn;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n, w0;
      int tA [$];
      int tB [$];
      int bad;
      for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
      lastRd = '{32'h0, 32'h0};
      reset_n = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
      b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;

      // reset values with a request pending, then first-grant latency
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_ack", a_ack, 0);
      check("rst_a_err", a_err, 0);
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_ack", b_ack, 0);
      check("rst_b_err", b_err, 0);
      check("rst_b_rdata", b_rdata, 0);
      check("rst_wren", Mem_WrEn, 0);
      check("rst_addr", ALU_MEM_Addr, 0);
      check("rst_datain", MEM_DataIn, 0);
      expectOp(0, 1'b0, 32'h0, 32'h0);
      reset_n = 1'b1;
      n = 0;
      while (n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (a_ack) break;
      end
      check("first_ack_latency", n, 3);
      a_req = 1'b0;

      // write then read back through port A
      w0 = wrCount;
      doReq(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      check("t2_write_count", wrCount - w0, 1);
      check("t2_write_addr", lastWrAddr, 32'h10);
      doReq(0, 1'b0, 32'h10, 32'h0);
      check("t2_rdata", a_rdata, 32'hDEAD_BEEF);

      // both ports held from reset: grants alternate A,B,A,B, 3 cycles apart
      doReset();
      expectOp(0, 1'b0, 32'h100, 32'h0);
      expectOp(1, 1'b0, 32'h200, 32'h0);
      expectOp(0, 1'b0, 32'h100, 32'h0);
      expectOp(1, 1'b0, 32'h200, 32'h0);
      a_we = 1'b0; a_addr = 32'h100; b_we = 1'b0; b_addr = 32'h200;
      a_req = 1'b1; b_req = 1'b1;
      fork
         begin
            for (int k = 0; k < 40 && tA.size() < 2; k++) begin
               @(negedge clk);
               if (a_ack) tA.push_back(cyc);
            end
            a_req = 1'b0;
         end
         begin
            for (int k = 0; k < 40 && tB.size() < 2; k++) begin
               @(negedge clk);
               if (b_ack) tB.push_back(cyc);
            end
            b_req = 1'b0;
         end
      join
      check("rr_grant_count", {tA.size(), tB.size()}, {32'd2, 32'd2});
      if (tA.size() == 2 && tB.size() == 2) begin
         check("rr_a_then_b", tB[0] - tA[0], 3);
         check("rr_b_then_a", tA[1] - tB[0], 3);
         check("rr_a_then_b2", tB[1] - tA[1], 3);
      end

      // misaligned write on port B: no RAM write, err, word unchanged
      w0 = wrCount;
      doReq(1, 1'b1, 32'h22, 32'h55AA_55AA);
      check("t4_err", b_err, 1);
      @(negedge clk);
      check("t4_no_write", wrCount - w0, 0);
      doReq(1, 1'b0, 32'h20, 32'h0);

      // reset during ACCESS of a write, then during RESP of a read
      @(posedge clk);
      #1;
      a_we = 1'b1; a_addr = 32'h80; a_wdata = 32'hCAFE_F00D; a_req = 1'b1;
      @(posedge clk);
      #2;
      check("t5_wren_in_access", Mem_WrEn, 1);
      reset_n = 1'b0;
      a_req = 1'b0;
      lastRd = '{32'h0, 32'h0};
      #1;
      check("t5_wren_drop", Mem_WrEn, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      a_we = 1'b0; a_addr = 32'h10; a_req = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b0;
      a_req = 1'b0;
      #1;
      check("t5_no_ack", a_ack, 0);
      check("t5_wren_zero", Mem_WrEn, 0);
      check("t5_rdata_cleared", a_rdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      doReq(1, 1'b0, 32'h10, 32'h0);

      // B read result held while A keeps writing a neighbouring word
      doReq(0, 1'b1, 32'h40, 32'h1234);
      doReq(1, 1'b0, 32'h40, 32'h0);
      for (int k = 0; k < 4; k++) doReq(0, 1'b1, 32'h44, $urandom);
      check("t6_b_rdata_stable", b_rdata, 32'h1234);

      // concurrent random traffic, disjoint word ranges per port
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               int idx, mis;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               idx = $urandom_range(0, 7);
               mis = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
               doReq(0, 1'($urandom_range(0, 1)), 32'(idx * 4 + mis), $urandom);
            end
         end
         begin
            for (int k = 0; k < 30; k++) begin
               int idx, mis;
               repeat ($urandom_range(0, 3)) @(posedge clk);
               idx = 512 + $urandom_range(0, 7);
               mis = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
               doReq(1, 1'($urandom_range(0, 1)), 32'(idx * 4 + mis), $urandom);
            end
         end
      join

      repeat (5) @(negedge clk);
      check("a_queue_drained", expAQ.size(), 0);
      check("b_queue_drained", expBQ.size(), 0);
      check("write_count", wrCount, expWr);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (ram[i] !== refMem[i]) bad++;
      check("ram_contents", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
